kb_scan_ctrl: RTL and testbench

- Sequencing controller for the PS/2 keyboard reader datapath (shift register plus parity checker).
- Synchronises the reader's avail flag into the system clock domain and captures each validated byte.
- Decodes E0 (extended) and F0 (break) prefix sequences into complete key events, queued in a small FWFT FIFO with valid/ready handshake.
- Drives the shift register's clear so each frame starts from an empty register; recovers from stalled partial sequences by timeout.

---
 rtl/kb_pkg.sv | 26 ++
 rtl/kb_event_fifo.sv | 63 ++++++
 rtl/kb_scan_ctrl.sv | 116 +++++++++++
 tb/tb_kb_scan_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Shared constants, FSM state encoding and event record for the PS/2 scan controller.
package kb_pkg;

  localparam logic [7:0] KB_PFX_EXT = 8'hE0;
  localparam logic [7:0] KB_PFX_BRK = 8'hF0;
  localparam logic [7:0] KB_ERR0    = 8'h00;
  localparam logic [7:0] KB_ERR1    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } kb_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } kb_event_t;

  function automatic logic kb_is_err(input logic [7:0] b);
    return (b == KB_ERR0) || (b == KB_ERR1);
  endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// First-word fall-through queue of key events; the head holds its last value once drained.
module kb_event_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  kb_event_t data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output kb_event_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  kb_event_t       mem_q [DEPTH];
  kb_event_t       last_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_CNT);
  assign do_pop  = pop_i & ~empty_o;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  assign head_o = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/kb_scan_ctrl.sv
// PS/2 reader sequencer: syncs avail, decodes E0/F0 prefixes into key events, drives reader clear.
module kb_scan_ctrl
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_CYCLES = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kb_avail,
  input  logic [7:0] kb_data,
  output logic       sr_clear,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       overflow
);

  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    sync_q;
  kb_state_e     state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          ovf_q;
  logic          capture, push, pop, fifo_full, fifo_empty;
  kb_event_t     ev_d, head;

  // Two flops for metastability, the third only for rising-edge detection.
  assign capture = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    ev_d      = '{code: kb_data, ext: 1'b0, brk: 1'b0};
    tmo_cnt_d = '0;
    clr_cnt_d = (clr_cnt_q != '0) ? clr_cnt_q - 1'b1 : '0;
    if (capture) begin
      clr_cnt_d = CLR_LOAD;
      case (state_q)
        ST_IDLE: begin
          if (kb_data == KB_PFX_EXT)      state_d = ST_E0;
          else if (kb_data == KB_PFX_BRK) state_d = ST_F0;
          else if (!kb_is_err(kb_data))   push = 1'b1;
        end
        ST_E0: begin
          if (kb_data == KB_PFX_BRK)      state_d = ST_E0F0;
          else if (kb_data == KB_PFX_EXT) state_d = ST_E0;
          else begin
            state_d  = ST_IDLE;
            push     = !kb_is_err(kb_data);
            ev_d.ext = 1'b1;
          end
        end
        ST_F0, ST_E0F0: begin
          state_d  = ST_IDLE;
          push     = !(kb_is_err(kb_data) || kb_data == KB_PFX_EXT || kb_data == KB_PFX_BRK);
          ev_d.ext = (state_q == ST_E0F0);
          ev_d.brk = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // Capture takes priority, so an abandoned sequence only happens on a quiet cycle.
      if (tmo_cnt_q == TMO_LAST) begin
        state_d   = ST_IDLE;
        clr_cnt_d = CLR_LOAD;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      clr_cnt_q <= CLR_LOAD;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], kb_avail};
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign pop = ev_ready & ~fifo_empty;

  kb_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .data_i  (ev_d),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign sr_clear = (clr_cnt_q != '0);
  assign ev_valid = ~fifo_empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Directed bench for kb_scan_ctrl: stimulus queues expected events, a monitor pops them on handshakes.
module tb_kb_scan_ctrl;
  import kb_pkg::*;

  localparam int TMO = 50000;

  logic       clk = 1'b0;
  logic       reset, kb_avail, ev_ready;
  logic [7:0] kb_data;
  logic       sr_clear, ev_valid, ev_ext, ev_break, overflow;
  logic [7:0] ev_code;

  kb_scan_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .kb_avail (kb_avail),
    .kb_data  (kb_data),
    .sr_clear (sr_clear),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_break (ev_break),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic sr_hist [0:65535];
  logic v_hist  [0:65535];
  always @(negedge clk) begin
    if (cyc < 65536) begin
      sr_hist[cyc] = sr_clear;
      v_hist[cyc]  = ev_valid;
    end
  end

  kb_event_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic kb_event_t mk(input logic [7:0] c, input logic x, input logic b);
    mk = '{code: c, ext: x, brk: b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin : monitor
    kb_event_t got, want;
    if (!reset && ev_valid && ev_ready) begin
      got = mk(ev_code, ev_ext, ev_break);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got code=%02h ext=%0d brk=%0d expected none",
                 got.code, got.ext, got.brk);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL event: got code=%02h ext=%0d brk=%0d expected code=%02h ext=%0d brk=%0d",
                   got.code, got.ext, got.brk, want.code, want.ext, want.brk);
        end else begin
          $display("pop code=%02h ext=%0d brk=%0d", got.code, got.ext, got.brk);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit exp_push, input kb_event_t e, output int cap);
    if (exp_push) exp_q.push_back(e);
    kb_data  = b;
    kb_avail = 1'b1;
    cap      = cyc + 3;
    tick(5);
    kb_avail = 1'b0;
    tick(4);
  endtask

  task automatic check_sr_window(input int start);
    for (int i = 0; i < 4; i++) check($sformatf("sr_clear_hi[%0d]", i), 32'(sr_hist[start + i]), 1);
    check("sr_clear_lo", 32'(sr_hist[start + 4]), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sr_clear"}, 32'(sr_clear), 1);
    check({tag, "_ev_valid"}, 32'(ev_valid), 0);
    check({tag, "_ev_code"},  32'(ev_code), 0);
    check({tag, "_ev_ext"},   32'(ev_ext), 0);
    check({tag, "_ev_break"}, 32'(ev_break), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  task automatic release_reset();
    int r;
    tick(2);
    reset = 1'b0;
    r = cyc;
    tick(6);
    check_sr_window(r);
  endtask

  initial begin
    int cap, dummy, first;
    kb_event_t none;
    none     = mk(8'h00, 1'b0, 1'b0);
    reset    = 1'b1;
    kb_avail = 1'b0;
    kb_data  = 8'h00;
    ev_ready = 1'b0;
    #23;
    check_reset_outputs("por");
    release_reset();

    // Make code with a long avail level: one event, exact latency and clear width.
    send(8'h1C, 1'b1, mk(8'h1C, 1'b0, 1'b0), cap);
    check("valid_before_cap", 32'(v_hist[cap - 1]), 0);
    check("valid_at_cap", 32'(v_hist[cap]), 1);
    check("sr_clear_before_cap", 32'(sr_hist[cap - 1]), 0);
    check_sr_window(cap);
    ev_ready = 1'b1;
    tick(3);
    check("single_event", 32'(ev_valid), 0);
    check("hold_code_when_empty", 32'(ev_code), 32'h1C);

    // Prefix sequences, malformed sequences and keyboard error bytes.
    send(8'hF0, 1'b0, none, dummy);
    send(8'h1C, 1'b1, mk(8'h1C, 1'b0, 1'b1), dummy);
    send(8'h2A, 1'b1, mk(8'h2A, 1'b0, 1'b0), dummy);
    send(8'hE0, 1'b0, none, dummy);
    send(8'hF0, 1'b0, none, dummy);
    send(8'h74, 1'b1, mk(8'h74, 1'b1, 1'b1), dummy);
    send(8'hE0, 1'b0, none, dummy);
    send(8'h75, 1'b1, mk(8'h75, 1'b1, 1'b0), dummy);
    send(8'hE0, 1'b0, none, dummy);
    send(8'hE0, 1'b0, none, dummy);
    send(8'h6B, 1'b1, mk(8'h6B, 1'b1, 1'b0), dummy);
    send(8'h00, 1'b0, none, dummy);
    send(8'hFF, 1'b0, none, dummy);
    send(8'hF0, 1'b0, none, dummy);
    send(8'hE0, 1'b0, none, dummy);
    send(8'h16, 1'b1, mk(8'h16, 1'b0, 1'b0), dummy);

    // Stalled break prefix is abandoned exactly TMO cycles after its capture.
    send(8'hF0, 1'b0, none, cap);
    tick(TMO);
    first = -1;
    for (int k = cap + 5; k <= cap + TMO + 5; k++) begin
      if (sr_hist[k] === 1'b1) begin
        first = k;
        break;
      end
    end
    check("timeout_cycle", 32'(first - cap), TMO);
    check("timeout_clear_hi", 32'(sr_hist[cap + TMO + 3]), 1);
    check("timeout_clear_lo", 32'(sr_hist[cap + TMO + 4]), 0);
    check("timeout_no_event", 32'(ev_valid), 0);
    send(8'h1C, 1'b1, mk(8'h1C, 1'b0, 1'b0), dummy);

    // Fill the queue, drop one, then push while full alongside a pop.
    ev_ready = 1'b0;
    send(8'h15, 1'b1, mk(8'h15, 1'b0, 1'b0), dummy);
    send(8'h1D, 1'b1, mk(8'h1D, 1'b0, 1'b0), dummy);
    send(8'h24, 1'b1, mk(8'h24, 1'b0, 1'b0), dummy);
    send(8'h2D, 1'b1, mk(8'h2D, 1'b0, 1'b0), dummy);
    send(8'h2C, 1'b0, none, dummy);
    check("overflow_set", 32'(overflow), 1);
    check("full_valid", 32'(ev_valid), 1);
    check("full_head", 32'(ev_code), 32'h15);
    exp_q.push_back(mk(8'h35, 1'b0, 1'b0));
    kb_data  = 8'h35;
    kb_avail = 1'b1;
    tick(2);
    ev_ready = 1'b1;
    tick(3);
    kb_avail = 1'b0;
    tick(10);
    check("overflow_kept", 32'(overflow), 1);
    check("full_drained", 32'(ev_valid), 0);
    check("full_queue_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset part-way through an E0 sequence.
    send(8'hE0, 1'b0, none, dummy);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("seq_rst");
    release_reset();
    send(8'h1C, 1'b1, mk(8'h1C, 1'b0, 1'b0), dummy);

    // Asynchronous reset while the reader clear is still active.
    exp_q.push_back(mk(8'h2B, 1'b0, 1'b0));
    kb_data  = 8'h2B;
    kb_avail = 1'b1;
    tick(4);
    check("mid_clear_active", 32'(sr_clear), 1);
    check("mid_clear_code", 32'(ev_code), 32'h2B);
    #2;
    kb_avail = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_outputs("clr_rst");
    release_reset();
    send(8'h1C, 1'b1, mk(8'h1C, 1'b0, 1'b0), dummy);

    tick(10);
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
